// File: rtl/score_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_port_arbiter_pkg
// Description : Shared types and constants for the score port arbiter:
//               FSM state encoding, default score register index, datapath
//               widths and the signed-delta width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package score_port_arbiter_pkg;

    // Arbiter FSM: IDLE may inject, SETTLE blocks one cycle after an inject
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } arb_state_t;

    localparam int SCORE_REG_DEFAULT = 30;
    localparam int SCORE_W           = 32;
    localparam int RF_IDX_W          = 5;

    // Score plus pending is formed with the score sign-extended and one
    // guard bit, so the sum of two in-range operands can never wrap.
    localparam int SUM_W             = SCORE_W + 2;

    // Width of a signed value able to hold +/- n_moles
    function automatic int delta_width(input int n_moles);
        return $clog2(n_moles + 1) + 1;
    endfunction

endpackage : score_port_arbiter_pkg
`default_nettype wire

// File: rtl/score_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : score_port_arbiter_if
// Description : Bundle between the processor / mole logic / regfile side and
//               the score port arbiter.
//   hit, miss   : per-mole one-cycle event pulses
//   score_cur   : score readback from the regfile
//   cpu_we/rd/wdata : processor regfile write request
//   rf_we/rd/wdata  : arbitrated regfile write
//   cpu_stall   : processor hold request
//   pending_nz, game_won, ovf : status
//   modport master : environment side, slave : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface score_port_arbiter_if #(
    parameter int N_MOLES = 4
);
    import score_port_arbiter_pkg::*;

    logic [N_MOLES-1:0]  hit;
    logic [N_MOLES-1:0]  miss;
    logic [SCORE_W-1:0]  score_cur;
    logic                cpu_we;
    logic [RF_IDX_W-1:0] cpu_rd;
    logic [SCORE_W-1:0]  cpu_wdata;
    logic                rf_we;
    logic [RF_IDX_W-1:0] rf_rd;
    logic [SCORE_W-1:0]  rf_wdata;
    logic                cpu_stall;
    logic                pending_nz;
    logic                game_won;
    logic                ovf;

    modport master (
        output hit, miss, score_cur, cpu_we, cpu_rd, cpu_wdata,
        input  rf_we, rf_rd, rf_wdata, cpu_stall, pending_nz, game_won, ovf
    );

    modport slave (
        input  hit, miss, score_cur, cpu_we, cpu_rd, cpu_wdata,
        output rf_we, rf_rd, rf_wdata, cpu_stall, pending_nz, game_won, ovf
    );

endinterface : score_port_arbiter_if
`default_nettype wire

// File: rtl/score_port_arbiter_event_popcount.sv
`default_nettype none
// ============================================================================
// Module      : event_popcount
// Description : Combinational per-cycle score delta from the mole channels:
//               delta = popcount(hit) - popcount(miss), signed.
//   hit   in  N_MOLES   hit pulses
//   miss  in  N_MOLES   miss pulses
//   delta out DELTA_W   signed net delta
// Revision    : 1.0 - initial release
// ============================================================================
module event_popcount
    import score_port_arbiter_pkg::*;
#(
    parameter int N_MOLES = 4,
    parameter int DELTA_W = delta_width(N_MOLES)
) (
    input  logic [N_MOLES-1:0]        hit,
    input  logic [N_MOLES-1:0]        miss,
    output logic signed [DELTA_W-1:0] delta
);

    logic [DELTA_W-1:0] w_hits;
    logic [DELTA_W-1:0] w_misses;

    // Counts never exceed N_MOLES, so the unsigned difference read back as
    // two's complement is the exact signed delta.
    always_comb begin
        w_hits   = '0;
        w_misses = '0;
        for (int i = 0; i < N_MOLES; i++) begin
            w_hits   = w_hits   + DELTA_W'(hit[i]);
            w_misses = w_misses + DELTA_W'(miss[i]);
        end
        delta = $signed(w_hits - w_misses);
    end

endmodule : event_popcount
`default_nettype wire

// File: rtl/score_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : score_port_arbiter
// Description : Shares the regfile write port between the CPU and the mole
//               game. Hit/miss events accumulate into a saturating signed
//               pending delta, which is written into the score register
//               (clamped to 0..SCORE_MAX) on a cycle the CPU leaves the port
//               free. One SETTLE cycle follows each inject so score_cur
//               reflects the write before the next one is formed.
//   clk    in  1   clk25
//   reset  in  1   synchronous, active-high
//   bus    slave modport of score_port_arbiter_if (events, CPU write
//          request, score readback, arbitrated write, status)
// Configuration macro: SCORE_STARVE_GUARD_EN
//   defined : after STARVE_CYC consecutive blocked cycles the inject is
//             forced and cpu_stall pulses for that cycle
//   undefined : CPU always has priority, cpu_stall stays 0
// Revision    : 1.0 - initial release
// ============================================================================
module score_port_arbiter
    import score_port_arbiter_pkg::*;
#(
    parameter int N_MOLES   = 4,
    parameter int SCORE_REG = SCORE_REG_DEFAULT,
    parameter int SCORE_MAX = 255,
    parameter int WIN_SCORE = 12,
    parameter int PEND_W    = 8
`ifdef SCORE_STARVE_GUARD_EN
    ,
    parameter int STARVE_CYC = 64
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    score_port_arbiter_if.slave  bus
);

    localparam int c_DELTA_W = delta_width(N_MOLES);
    localparam int c_ACC_W   = ((PEND_W > c_DELTA_W) ? PEND_W : c_DELTA_W) + 1;

    // Symmetric saturation limits; the most negative code is never used
    localparam logic signed [c_ACC_W-1:0] c_PEND_MAX = c_ACC_W'((1 << (PEND_W - 1)) - 1);
    localparam logic signed [c_ACC_W-1:0] c_PEND_MIN = -c_PEND_MAX;

    localparam logic signed [SUM_W-1:0]   c_SCORE_MAX_S = SUM_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0]        c_SCORE_MAX_U = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0]        c_WIN_SCORE   = SCORE_W'(WIN_SCORE);
    localparam logic [RF_IDX_W-1:0]       c_SCORE_IDX   = RF_IDX_W'(SCORE_REG);

    arb_state_t                   r_state;
    arb_state_t                   w_state_next;
    logic signed [PEND_W-1:0]     r_pending;
    logic signed [PEND_W-1:0]     w_pending_next;
    logic                         r_game_won;
    logic                         r_ovf;

    logic signed [c_DELTA_W-1:0]  w_delta_raw;
    logic signed [c_DELTA_W-1:0]  w_delta;
    logic signed [c_ACC_W-1:0]    w_acc_sum;
    logic                         w_acc_sat;
    logic signed [SUM_W-1:0]      w_score_sum;
    logic [SCORE_W-1:0]           w_score_clamped;
    logic                         w_pending_nz;
    logic                         w_inject;
    logic                         w_starve_fire;

    // ------------------------------------------------------------------
    // Event delta; frozen once the game is won
    // ------------------------------------------------------------------
    event_popcount #(
        .N_MOLES (N_MOLES),
        .DELTA_W (c_DELTA_W)
    ) u_event_popcount (
        .hit   (bus.hit),
        .miss  (bus.miss),
        .delta (w_delta_raw)
    );

    assign w_delta      = r_game_won ? '0 : w_delta_raw;
    assign w_pending_nz = (r_pending != '0);

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef SCORE_STARVE_GUARD_EN
    localparam int                     c_STARVE_W     = $clog2(STARVE_CYC + 1);
    localparam logic [c_STARVE_W-1:0]  c_STARVE_LIMIT = c_STARVE_W'(STARVE_CYC);

    logic [c_STARVE_W-1:0] r_starve_cnt;
    logic                  w_starve_blocked;

    assign w_starve_blocked = (r_state == ST_IDLE) && bus.cpu_we && w_pending_nz;
    assign w_starve_fire    = w_starve_blocked && (r_starve_cnt == c_STARVE_LIMIT);

    // Counts consecutive blocked IDLE cycles; firing always injects, which
    // clears it, so it never passes the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_inject) begin
            r_starve_cnt <= '0;
        end else if (w_starve_blocked) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end
`else
    assign w_starve_fire = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Score to write: signed(score_cur) + pending, clamped to 0..SCORE_MAX
    // ------------------------------------------------------------------
    always_comb begin
        w_score_sum = $signed({{(SUM_W - SCORE_W){bus.score_cur[SCORE_W-1]}}, bus.score_cur})
                    + SUM_W'(r_pending);
        w_score_clamped = w_score_sum[SCORE_W-1:0];
        if (w_score_sum[SUM_W-1]) begin
            w_score_clamped = '0;
        end else if (w_score_sum > c_SCORE_MAX_S) begin
            w_score_clamped = c_SCORE_MAX_U;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and write-port mux
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_inject      = 1'b0;
        bus.rf_we     = bus.cpu_we;
        bus.rf_rd     = bus.cpu_rd;
        bus.rf_wdata  = bus.cpu_wdata;
        bus.cpu_stall = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pending_nz && (!bus.cpu_we || w_starve_fire)) begin
                    w_inject      = 1'b1;
                    w_state_next  = ST_SETTLE;
                    bus.rf_we     = 1'b1;
                    bus.rf_rd     = c_SCORE_IDX;
                    bus.rf_wdata  = w_score_clamped;
                    bus.cpu_stall = w_starve_fire;
                end
            end
            ST_SETTLE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator: an inject consumes pending, so the same-cycle delta
    // becomes the new pending instead of being added to it.
    // ------------------------------------------------------------------
    always_comb begin
        w_acc_sat = 1'b0;
        if (w_inject) begin
            w_acc_sum = c_ACC_W'(w_delta);
        end else begin
            w_acc_sum = c_ACC_W'(r_pending) + c_ACC_W'(w_delta);
        end
        w_pending_next = w_acc_sum[PEND_W-1:0];
        if (w_acc_sum > c_PEND_MAX) begin
            w_pending_next = c_PEND_MAX[PEND_W-1:0];
            w_acc_sat      = 1'b1;
        end else if (w_acc_sum < c_PEND_MIN) begin
            w_pending_next = c_PEND_MIN[PEND_W-1:0];
            w_acc_sat      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= '0;
            r_ovf      <= 1'b0;
            r_game_won <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_ovf      <= r_ovf | w_acc_sat;
            r_game_won <= r_game_won | (bus.score_cur >= c_WIN_SCORE);
        end
    end

    assign bus.pending_nz = w_pending_nz;
    assign bus.game_won   = r_game_won;
    assign bus.ovf        = r_ovf;

endmodule : score_port_arbiter
`default_nettype wire
